// File: rtl/master_bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter.
//   ArbState              : ownership state encoding
//   ARB_DEFAULT_MAX_HOLD  : default back-to-back transfer limit while the other master waits
//   ARB_DEFAULT_TIMEOUT   : default stall watchdog length in cycles
//   ARB_HOLD_W / ARB_WD_W : counter widths sized for the legal parameter ranges
package master_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_A = 2'd1,
    ARB_OWN_B = 2'd2
  } ArbState;

  localparam int ARB_DEFAULT_MAX_HOLD = 16;
  localparam int ARB_DEFAULT_TIMEOUT  = 255;

  // MAX_HOLD <= 255, TIMEOUT_CYCLES <= 65535
  localparam int ARB_HOLD_W = 8;
  localparam int ARB_WD_W   = 16;

endpackage

// File: rtl/master_bus_watchdog.sv
// Saturating stall counter for the bus arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   enable   : owner is stalled this cycle (request high, no completion)
//   clear    : restart the count (completion seen or ownership changing)
//   expire   : high in the cycle the count reaches TIMEOUT_CYCLES-1 while enabled
module master_bus_watchdog
  import master_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ARB_DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam logic [ARB_WD_W-1:0] WD_LAST = ARB_WD_W'(TIMEOUT_CYCLES - 1);

  logic [ARB_WD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != WD_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Deliberately independent of clear: the arbiter derives clear from its
  // next state, which itself depends on expire.
  assign expire = enable && (cnt_q == WD_LAST);

endmodule

// File: rtl/master_bus_arbiter.sv
// Ownership arbiter for the two-master bus multiplexer.
//   clk, rst   : clock, asynchronous active-high reset
//   reqA, reqB : transfer pending from master A / B, held until busDone
//   lockA      : A asks to keep the bus past the hold limit
//   busDone    : slave completes the current transfer this cycle
//   useA       : mux select, 1 = A drives the bus (parked on last owner when idle)
//   grantA/B   : A / B owns the bus
//   busTimeout : one-cycle pulse when the stall watchdog fires
//   grantCntA/B: grant counters, present only when MASTER_BUS_ARB_STATS_EN is defined
// Round-robin on ties, hold-limit preemption, A-only lock, stall watchdog.
module master_bus_arbiter
  import master_bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD       = ARB_DEFAULT_MAX_HOLD,
  parameter int TIMEOUT_CYCLES = ARB_DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqA,
  input  logic        reqB,
  input  logic        lockA,
  input  logic        busDone,
  output logic        useA,
  output logic        grantA,
  output logic        grantB,
  output logic        busTimeout
`ifdef MASTER_BUS_ARB_STATS_EN
  ,
  output logic [31:0] grantCntA,
  output logic [31:0] grantCntB
`endif
);

  localparam logic [ARB_HOLD_W-1:0] HOLD_LAST = ARB_HOLD_W'(MAX_HOLD - 1);

  ArbState               state_q, state_d;
  logic                  last_a_q, last_a_d;   // lastOwner == A
  logic [ARB_HOLD_W-1:0] hold_q, hold_d;
  logic                  use_a_q, use_a_d;
  logic                  timeout_q, timeout_d;

  logic    owned, owner_is_a, owner_req, other_req, lock_hold;
  logic    wd_en, wd_clear, wd_expire;
  ArbState other_state;

  assign owned       = (state_q != ARB_IDLE);
  assign owner_is_a  = (state_q == ARB_OWN_A);
  assign owner_req   = owner_is_a ? reqA : reqB;
  assign other_req   = owner_is_a ? reqB : reqA;
  assign other_state = owner_is_a ? ARB_OWN_B : ARB_OWN_A;
  // lockA has no effect while B owns the bus
  assign lock_hold   = owner_is_a && lockA;

  assign wd_en    = owned && owner_req && !busDone;
  assign wd_clear = busDone || !owned || (state_d != state_q);

  master_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .enable(wd_en),
    .clear (wd_clear),
    .expire(wd_expire)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      last_a_q  <= 1'b0;
      hold_q    <= '0;
      use_a_q   <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_a_q  <= last_a_d;
      hold_q    <= hold_d;
      use_a_q   <= use_a_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    last_a_d  = last_a_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        hold_d = '0;
        if (reqA && reqB) begin
          state_d = last_a_q ? ARB_OWN_B : ARB_OWN_A;
        end else if (reqA) begin
          state_d = ARB_OWN_A;
        end else if (reqB) begin
          state_d = ARB_OWN_B;
        end
      end
      ARB_OWN_A, ARB_OWN_B: begin
        if (wd_expire) begin
          state_d   = ARB_IDLE;
          timeout_d = 1'b1;
          last_a_d  = owner_is_a;
          hold_d    = '0;
        end else if (!owner_req) begin
          // direct handoff, no idle bubble
          state_d  = other_req ? other_state : ARB_IDLE;
          last_a_d = owner_is_a;
          hold_d   = '0;
        end else if (busDone && (hold_q == HOLD_LAST) && other_req && !lock_hold) begin
          state_d  = other_state;
          last_a_d = owner_is_a;
          hold_d   = '0;
        end else if (busDone && (hold_q != HOLD_LAST)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        hold_d  = '0;
      end
    endcase

    // select follows the next owner; idle keeps it parked
    use_a_d = use_a_q;
    if (state_d == ARB_OWN_A) begin
      use_a_d = 1'b1;
    end else if (state_d == ARB_OWN_B) begin
      use_a_d = 1'b0;
    end
  end

  // Outputs, all taken from registers
  always_comb begin
    grantA     = (state_q == ARB_OWN_A);
    grantB     = (state_q == ARB_OWN_B);
    useA       = use_a_q;
    busTimeout = timeout_q;
  end

`ifdef MASTER_BUS_ARB_STATS_EN
  logic [31:0] grant_cnt_a_q, grant_cnt_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_a_q <= '0;
      grant_cnt_b_q <= '0;
    end else begin
      if ((state_d == ARB_OWN_A) && (state_q != ARB_OWN_A)) begin
        grant_cnt_a_q <= grant_cnt_a_q + 1'b1;
      end
      if ((state_d == ARB_OWN_B) && (state_q != ARB_OWN_B)) begin
        grant_cnt_b_q <= grant_cnt_b_q + 1'b1;
      end
    end
  end

  assign grantCntA = grant_cnt_a_q;
  assign grantCntB = grant_cnt_b_q;
`endif

endmodule

// File: tb/tb_master_bus_arbiter.sv
// Bench for master_bus_arbiter (MAX_HOLD=4, TIMEOUT_CYCLES=8). Directed
// vectors push the hand-computed outputs expected after the next edge into a
// scoreboard queue; a monitor pops and compares them on the falling edge.
// Grant counter checks are included when MASTER_BUS_ARB_STATS_EN is defined.
module tb_master_bus_arbiter;

  localparam int MH = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic reqA = 1'b0, reqB = 1'b0, lockA = 1'b0, busDone = 1'b0;
  logic useA, grantA, grantB, busTimeout;
`ifdef MASTER_BUS_ARB_STATS_EN
  logic [31:0] grantCntA, grantCntB;
`endif

  master_bus_arbiter #(
    .MAX_HOLD      (MH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .reqA      (reqA),
    .reqB      (reqB),
    .lockA     (lockA),
    .busDone   (busDone),
    .useA      (useA),
    .grantA    (grantA),
    .grantB    (grantB),
    .busTimeout(busTimeout)
`ifdef MASTER_BUS_ARB_STATS_EN
    ,
    .grantCntA (grantCntA),
    .grantCntB (grantCntB)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] outs;   // {grantA, grantB, useA, busTimeout}
    string      nm;
  } exp_t;

  exp_t sb_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", nm, act);
    end
  endtask

  // Apply inputs for one cycle; expected {gA,gB,uA,to} appear after the next edge.
  task automatic step(input logic ra, input logic rb, input logic la, input logic bd,
                      input logic [3:0] exp_outs, input string nm);
    exp_t e;
    @(negedge clk);
    reqA = ra;
    reqB = rb;
    lockA = la;
    busDone = bd;
    e.cyc = cyc + 1;
    e.outs = exp_outs;
    e.nm = nm;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        check(e.nm, {28'd0, grantA, grantB, useA, busTimeout}, {28'd0, e.outs});
      end
    end
  end

  // Global bound
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", {28'd0, grantA, grantB, useA, busTimeout}, 32'b0010);
`ifdef MASTER_BUS_ARB_STATS_EN
    check("reset_cntA", grantCntA, 32'd0);
    check("reset_cntB", grantCntB, 32'd0);
`endif
    rst = 1'b0;

    // Round-robin and direct handoff
    step(1, 1, 0, 0, 4'b1010, "tie_after_reset_A");
    step(0, 1, 0, 1, 4'b0100, "handoff_to_B");
    step(1, 1, 0, 0, 4'b0100, "B_keeps_while_req");
    step(1, 0, 0, 1, 4'b1010, "B_release_to_A");
    step(0, 0, 0, 1, 4'b0010, "A_release_idle");
    step(1, 1, 0, 0, 4'b0100, "tie_goes_B");
    step(0, 0, 0, 1, 4'b0000, "idle_parked_on_B");
    step(0, 0, 0, 1, 4'b0000, "idle_busdone_ignored");
    step(1, 0, 0, 0, 4'b1010, "grantA_next_cycle");
    step(0, 0, 0, 1, 4'b0010, "idle_parked_on_A");

    // Hold limit: four completions under A, then B
    step(1, 0, 0, 0, 4'b1010, "hold_grantA");
    step(1, 1, 0, 1, 4'b1010, "hold_done1");
    step(1, 1, 0, 1, 4'b1010, "hold_done2");
    step(1, 1, 0, 1, 4'b1010, "hold_done3");
    step(1, 1, 0, 1, 4'b0100, "hold_done4_preempt");
    step(1, 0, 0, 1, 4'b1010, "B_done_back_to_A");

    // Lock keeps A past the limit
    for (int i = 0; i < 6; i++) step(1, 1, 1, 1, 4'b1010, "lock_keeps_A");
    step(1, 1, 0, 1, 4'b0100, "unlock_preempt_B");

    // Watchdog: B stalls, fires after 8 owned cycles
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 4'b0100, "stall_B");
    step(0, 1, 0, 0, 4'b0001, "watchdog_fires");
    step(1, 1, 0, 0, 4'b1010, "tie_after_timeout_A");
    step(0, 1, 0, 1, 4'b0100, "handoff_B_before_rst");
    drain();

    // Asynchronous reset mid-cycle while B owns
    @(posedge clk);
    #2;
    check("pre_rst_grantB", {31'd0, grantB}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_outputs", {28'd0, grantA, grantB, useA, busTimeout}, 32'b0010);
    @(negedge clk);
    reqA = 1'b0;
    reqB = 1'b0;
    busDone = 1'b0;
    rst = 1'b0;
    step(0, 0, 0, 0, 4'b0010, "idle_after_rst");

    // Three A grants, two B grants
    step(1, 0, 0, 0, 4'b1010, "stat_A1");
    step(0, 1, 0, 1, 4'b0100, "stat_B1");
    step(1, 0, 0, 1, 4'b1010, "stat_A2");
    step(0, 1, 0, 1, 4'b0100, "stat_B2");
    step(1, 0, 0, 1, 4'b1010, "stat_A3");
    step(0, 0, 0, 1, 4'b0010, "stat_idle");
    drain();
`ifdef MASTER_BUS_ARB_STATS_EN
    check("grantCntA", grantCntA, 32'd3);
    check("grantCntB", grantCntB, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
